// File: rtl/demux_chan_deser.sv
// demux_chan_deser
//   Downstream consumer of a 1-to-4 bit demultiplexer. Each channel's serial
//   bit stream is assembled MSB-first into WIDTH-bit words. Every channel has
//   a one-deep holding register. A round-robin arbiter drains completed words
//   over a single valid/ready port, tagging each word with its channel number.
//   A word that completes while its channel's holding register is still
//   occupied is dropped and sets a sticky per-channel overflow flag.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   in_vld    in   a valid demux bit is present this cycle
//   sel       in   channel select (same value that drives the demux)
//   y         in   demux outputs, only y[sel] is used
//   out_vld   out  a completed word is offered
//   out_rdy   in   consumer accepts the offered word
//   out_ch    out  channel of the offered word (rr pointer when idle)
//   out_data  out  offered word, first-received bit in the MSB (0 when idle)
//   ovf       out  sticky per-channel overflow flags
//   ovf_clr   in   clears all ovf bits (a same-edge overflow still sets)
module demux_chan_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [1:0]       sel,
  input  logic [3:0]       y,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [1:0]       out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       ovf,
  input  logic             ovf_clr
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Grant is latched while the consumer stalls so the offer stays stable.
  typedef enum logic {ST_ARB, ST_STALL} state_e;

  state_e           state_q, state_d;
  logic [1:0]       lock_ch_q, lock_ch_d;

  logic [WIDTH-1:0] shreg_q [4];
  logic [WIDTH-1:0] shreg_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [WIDTH-1:0] hold_q  [4];
  logic [WIDTH-1:0] hold_d  [4];
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       ovf_q, ovf_d;
  logic [1:0]       rr_q, rr_d;

  logic             bit_in;
  logic [WIDTH-1:0] word_in;
  logic             last_bit;
  logic [1:0]       scan_ch;
  logic [1:0]       scan_idx;
  logic             scan_found;
  logic [1:0]       grant;
  logic             any_pend;
  logic             pop;

  // Incoming bit and the word it would form on the selected channel.
  always_comb begin
    bit_in   = y[sel];
    word_in  = {shreg_q[sel][WIDTH-2:0], bit_in};
    last_bit = in_vld && (cnt_q[sel] == CNT_LAST);
  end

  // Round-robin scan starting at rr.
  always_comb begin
    scan_ch    = rr_q;
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_q + 2'(i);
      if (!scan_found && pend_q[scan_idx]) begin
        scan_ch    = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  // Grant FSM: latch the offered channel on a stall, release on transfer.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    any_pend  = |pend_q;
    grant     = (state_q == ST_STALL) ? lock_ch_q : scan_ch;
    pop       = any_pend && out_rdy;
    case (state_q)
      ST_ARB: begin
        if (any_pend && !out_rdy) begin
          state_d   = ST_STALL;
          lock_ch_d = scan_ch;
        end
      end
      ST_STALL: begin
        if (out_rdy) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    out_vld  = any_pend;
    out_ch   = any_pend ? grant : rr_q;
    out_data = any_pend ? hold_q[grant] : '0;
    ovf      = ovf_q;
  end

  // Capture, completion, overflow and pop bookkeeping.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      shreg_d[c] = shreg_q[c];
      cnt_d[c]   = cnt_q[c];
      hold_d[c]  = hold_q[c];
    end
    pend_d = pend_q;
    ovf_d  = ovf_clr ? 4'b0000 : ovf_q;
    rr_d   = rr_q;

    if (pop) begin
      pend_d[grant] = 1'b0;
      rr_d          = grant + 2'd1;
    end

    if (in_vld) begin
      shreg_d[sel] = word_in;
      if (last_bit) begin
        cnt_d[sel] = '0;
        // A pop of this channel on the same edge frees the slot for the new word.
        if (!pend_q[sel] || (pop && (grant == sel))) begin
          hold_d[sel] = word_in;
          pend_d[sel] = 1'b1;
        end else begin
          ovf_d[sel] = 1'b1;
        end
      end else begin
        cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARB;
      lock_ch_q <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
      rr_q      <= '0;
      for (int c = 0; c < 4; c++) begin
        shreg_q[c] <= '0;
        cnt_q[c]   <= '0;
        hold_q[c]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      rr_q      <= rr_d;
      for (int c = 0; c < 4; c++) begin
        shreg_q[c] <= shreg_d[c];
        cnt_q[c]   <= cnt_d[c];
        hold_q[c]  <= hold_d[c];
      end
    end
  end

endmodule

// File: doc/demux_chan_deser.md
Name: demux_chan_deser

Overview:
- Downstream consumer of the 1-to-4 bit demultiplexer.
- Captures each channel's bit stream from the demux outputs and assembles it MSB-first into WIDTH-bit words, one per channel.
- Each channel has a one-deep holding register. A round-robin arbiter drains completed words over a single valid/ready output port.
- Tags each word with its channel number; flags per-channel overflow.

Parameters:
- WIDTH, 8, bits per assembled word (2..32).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_vld  input  1  a valid demux bit is present this cycle.
- sel  input  2  channel select, same value that drives the demux.
- y  input  4  demux outputs; only y[sel] is used.
- out_vld  output  1  a completed word is offered.
- out_rdy  input  1  consumer accepts the offered word.
- out_ch  output  2  channel of the offered word.
- out_data  output  WIDTH  offered word, first-received bit in the MSB.
- ovf  output  4  sticky per-channel overflow flags.
- ovf_clr  input  1  clears all ovf bits.

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over all other activity and discards partial words and pending words.
  - After the reset edge: all bit counters, shift registers and holding registers are 0; pending = 0; ovf = 0; rr pointer = 0.
  - Outputs after reset: out_vld = 0, out_ch = 0, out_data = 0.
- Capture:
  - On an edge with in_vld = 1, channel c = sel shifts in b = y[c]: shreg[c] <= {shreg[c][WIDTH-2:0], b}, and cnt[c] increments.
  - Other y bits are ignored, even if nonzero.
  - Channels not selected hold their state. in_vld = 0 changes nothing.
- Word completion:
  - A word completes when cnt[c] == WIDTH-1 and a bit is accepted.
  - On that edge: hold[c] <= {shreg[c][WIDTH-2:0], b}, cnt[c] <= 0, pending[c] <= 1.
  - Latency: out_vld can assert in the cycle after the last bit's edge.
- Overflow:
  - Condition: a word completes while pending[c] = 1 and that channel is not being popped on the same edge.
  - Result: the new word is dropped, hold[c] is unchanged, and ovf[c] <= 1.
  - The counter still wraps to 0.
- Simultaneous completion and pop on the same channel: the new word loads, pending[c] stays 1, and there is no overflow.
- ovf_clr:
  - Clears all ovf bits on the edge it is sampled.
  - If an overflow occurs on the same edge, the set wins for that channel.
- Arbiter (combinational grant):
  - out_vld = |pending.
  - out_ch = first channel with pending set, scanning from rr, rr+1, ... modulo 4.
  - out_data = hold[out_ch].
  - When out_vld = 0: out_ch = rr and out_data = 0.
- Handshake:
  - A transfer happens on an edge with out_vld & out_rdy: pending[out_ch] <= 0 (unless the simultaneous-completion rule applies) and rr <= out_ch + 1 (mod 4).
  - While out_vld = 1 and out_rdy = 0, out_ch and out_data are held stable. A newly pending channel does not preempt the offered channel.
  - Implementation: latch the granted channel while a stall is in progress; re-arbitrate only after a transfer, or when out_vld was low.
- Counters wrap silently. sel changing every cycle is legal: channels interleave independently.

Test Plan (WIDTH=8):
- Single channel: in_vld = 1, sel = 2, y[2] serially = 1,0,1,1,0,0,1,0 with out_rdy = 1 → next cycle out_vld = 1, out_ch = 2, out_data = 8'hB2; one cycle later out_vld = 0.
- Interleaved: alternate sel = 0 / 1 each cycle, sending 8'hA5 on ch0 and 8'h3C on ch1, out_rdy = 0 until both are pending → grants in order ch0 (0xA5), then ch1 (0x3C); rr ends at 2.
- Round-robin fairness: all four channels pending, out_rdy = 1 continuously, rr = 1 → out_ch sequence 1, 2, 3, 0 on consecutive cycles.
- Overflow: ch3 completes 0x11, out_rdy = 0, then ch3 completes 0x22 → ovf = 4'b1000 and out_data stays 0x11. Then out_rdy = 1 → 0x11 is delivered. Then ovf_clr → ovf = 0.
- Simultaneous pop and completion: ch0 holds 0x55 and is offered; the last bit of 0x66 arrives on the same edge as the out_rdy handshake → ovf[0] = 0, and the next cycle offers 0x66.
- Reset mid-word: 5 bits into ch1, with ch2 pending, assert rst for one cycle → out_vld = 0. Then 8 fresh bits 0xF0 on ch1 → exactly 0xF0 is delivered, with no residue from the discarded partial word.
